// File: rtl/sram_dp_param.sv
// Dual-port byte-writable SRAM that shares one clock between both ports.
// Each port has its own read pipeline: one stage for NOREG, or two stages for
// OUTREG. The write-port result on each port is set by WRITEMODE_A/B.
// Ports:
//   clk, rst_n            clock, async active-low reset (outputs/pipeline only)
//   cea/ceb               port enable
//   addra/addrb           word address
//   dia/dib, wea/web      write data, byte write enables (wex == 0 -> read)
//   rsta/rstb             sync output reset of that port's pipeline
//   doa/dob, valida/validb read result and its one-cycle valid strobe
//   collision             registered same-address conflict flag
module sram_dp_param #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter string       REGMODE     = "NOREG",
  parameter string       WRITEMODE_A = "NORMAL",
  parameter string       WRITEMODE_B = "NORMAL"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cea,
  input  logic                    ceb,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dia,
  input  logic [DATA_WIDTH-1:0]   dib,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic                    rsta,
  input  logic                    rstb,
  output logic [DATA_WIDTH-1:0]   doa,
  output logic [DATA_WIDTH-1:0]   dob,
  output logic                    valida,
  output logic                    validb,
  output logic                    collision
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam bit OUT_REG = (REGMODE == "OUTREG");
  localparam bit WT_A    = (WRITEMODE_A == "WRITETHROUGH");
  localparam bit RBW_A   = (WRITEMODE_A == "READBEFOREWRITE");
  localparam bit WT_B    = (WRITEMODE_B == "WRITETHROUGH");
  localparam bit RBW_B   = (WRITEMODE_B == "READBEFOREWRITE");

  // Byte merge: en_hi bytes take d_hi, else en_lo bytes take d_lo, else base.
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] d_hi,
    input logic [NB-1:0]         en_hi,
    input logic [DATA_WIDTH-1:0] d_lo,
    input logic [NB-1:0]         en_lo
  );
    logic [DATA_WIDTH-1:0] w;
    w = base;
    for (int unsigned i = 0; i < NB; i++) begin
      if (en_hi[i]) begin
        w[8*i +: 8] = d_hi[8*i +: 8];
      end else if (en_lo[i]) begin
        w[8*i +: 8] = d_lo[8*i +: 8];
      end
    end
    return w;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [NB-1:0]         wea_e, web_e;
  logic                  same_addr;
  logic                  wr_a, wr_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] new_a, new_b;
  logic                  res_v_a, res_v_b;
  logic [DATA_WIDTH-1:0] res_d_a, res_d_b;

  // Operation decode and post-write word; port A wins bytes written by both.
  always_comb begin
    wea_e     = cea ? wea : '0;
    web_e     = ceb ? web : '0;
    same_addr = (addra == addrb);
    wr_a      = |wea_e;
    wr_b      = |web_e;
    rd_a      = cea && !wr_a;
    rd_b      = ceb && !wr_b;
    old_a     = mem_q[addra];
    old_b     = mem_q[addrb];
    new_a     = merge_word(old_a, dia, wea_e, dib, same_addr ? web_e : NB'(0));
    new_b     = merge_word(old_b, dia, same_addr ? wea_e : NB'(0), dib, web_e);
    res_v_a   = rd_a || (wr_a && (WT_A || RBW_A));
    res_v_b   = rd_b || (wr_b && (WT_B || RBW_B));
    res_d_a   = (wr_a && WT_A) ? new_a : old_a;
    res_d_b   = (wr_b && WT_B) ? new_b : old_b;
  end

  // Storage: no reset of contents, writes suppressed while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n) begin
      if (wr_a) mem_q[addra] <= new_a;
      if (wr_b) mem_q[addrb] <= new_b;
    end
  end

  logic [DATA_WIDTH-1:0] da1_q, db1_q;
  logic                  va1_q, vb1_q;
  logic                  collision_q;

  // Port A first stage; data holds whenever there is no new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da1_q <= '0;
      va1_q <= 1'b0;
    end else if (rsta) begin
      da1_q <= '0;
      va1_q <= 1'b0;
    end else begin
      va1_q <= res_v_a;
      if (res_v_a) da1_q <= res_d_a;
    end
  end

  // Port B first stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db1_q <= '0;
      vb1_q <= 1'b0;
    end else if (rstb) begin
      db1_q <= '0;
      vb1_q <= 1'b0;
    end else begin
      vb1_q <= res_v_b;
      if (res_v_b) db1_q <= res_d_b;
    end
  end

  // Same-address conflict, flagged the cycle after it happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= cea && ceb && same_addr && (wr_a || wr_b);
    end
  end

  assign collision = collision_q;

  if (OUT_REG) begin : g_outreg
    logic [DATA_WIDTH-1:0] da2_q, db2_q;
    logic                  va2_q, vb2_q;

    // Port A output stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        da2_q <= '0;
        va2_q <= 1'b0;
      end else if (rsta) begin
        da2_q <= '0;
        va2_q <= 1'b0;
      end else begin
        va2_q <= va1_q;
        if (va1_q) da2_q <= da1_q;
      end
    end

    // Port B output stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db2_q <= '0;
        vb2_q <= 1'b0;
      end else if (rstb) begin
        db2_q <= '0;
        vb2_q <= 1'b0;
      end else begin
        vb2_q <= vb1_q;
        if (vb1_q) db2_q <= db1_q;
      end
    end

    assign doa    = da2_q;
    assign valida = va2_q;
    assign dob    = db2_q;
    assign validb = vb2_q;
  end else begin : g_noreg
    assign doa    = da1_q;
    assign valida = va1_q;
    assign dob    = db1_q;
    assign validb = vb1_q;
  end

endmodule

// File: tb/tb_sram_dp_param.sv
// Directed bench for sram_dp_param. Four instances share one stimulus:
// nr (NOREG, NORMAL), orr (OUTREG), wt (A WRITETHROUGH), rb (A READBEFOREWRITE).
module tb_sram_dp_param;

  logic        clk, rst_n, cea, ceb, rsta, rstb;
  logic [11:0] addra, addrb;
  logic [31:0] dia, dib;
  logic [3:0]  wea, web;

  logic [31:0] nr_doa, nr_dob, or_doa, or_dob, wt_doa, wt_dob, rb_doa, rb_dob;
  logic        nr_va, nr_vb, nr_col, or_va, or_vb, or_col;
  logic        wt_va, wt_vb, wt_col, rb_va, rb_vb, rb_col;

  int vectors = 0;
  int miscompares = 0;

  sram_dp_param u_nr (
    .clk(clk), .rst_n(rst_n), .cea(cea), .ceb(ceb), .addra(addra), .addrb(addrb),
    .dia(dia), .dib(dib), .wea(wea), .web(web), .rsta(rsta), .rstb(rstb),
    .doa(nr_doa), .dob(nr_dob), .valida(nr_va), .validb(nr_vb), .collision(nr_col));

  sram_dp_param #(.REGMODE("OUTREG")) u_or (
    .clk(clk), .rst_n(rst_n), .cea(cea), .ceb(ceb), .addra(addra), .addrb(addrb),
    .dia(dia), .dib(dib), .wea(wea), .web(web), .rsta(rsta), .rstb(rstb),
    .doa(or_doa), .dob(or_dob), .valida(or_va), .validb(or_vb), .collision(or_col));

  sram_dp_param #(.WRITEMODE_A("WRITETHROUGH")) u_wt (
    .clk(clk), .rst_n(rst_n), .cea(cea), .ceb(ceb), .addra(addra), .addrb(addrb),
    .dia(dia), .dib(dib), .wea(wea), .web(web), .rsta(rsta), .rstb(rstb),
    .doa(wt_doa), .dob(wt_dob), .valida(wt_va), .validb(wt_vb), .collision(wt_col));

  sram_dp_param #(.WRITEMODE_A("READBEFOREWRITE")) u_rb (
    .clk(clk), .rst_n(rst_n), .cea(cea), .ceb(ceb), .addra(addra), .addrb(addrb),
    .dia(dia), .dib(dib), .wea(wea), .web(web), .rsta(rsta), .rstb(rstb),
    .doa(rb_doa), .dob(rb_dob), .valida(rb_va), .validb(rb_vb), .collision(rb_col));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cea = 0; ceb = 0; wea = '0; web = '0; rsta = 0; rstb = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    cyc(); cyc();
    vectors++;
    if ({nr_doa, nr_dob, nr_va, nr_vb, nr_col} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_nr: got %h %h %b %b %b want all 0", nr_doa, nr_dob, nr_va, nr_vb, nr_col);
    end
    vectors++;
    if ({or_doa, or_dob, or_va, or_vb, or_col} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_or: got %h %h %b %b %b want all 0", or_doa, or_dob, or_va, or_vb, or_col);
    end
    rst_n = 1;
  endtask

  task automatic test_byte_write();
    idle(); cea = 1; addra = 12'd5; dia = 32'hAABBCCDD; wea = 4'hF;
    cyc();
    vectors++;
    if (nr_va !== 1'b0) begin miscompares++; $display("FAIL bw_normal_write_valid: got %b want 0", nr_va); end
    dia = 32'h11223344; wea = 4'b0010;
    cyc();
    wea = 4'h0;
    cyc();
    vectors++;
    if (nr_doa !== 32'hAABB33DD || nr_va !== 1'b1) begin
      miscompares++; $display("FAIL bw_read_nr: got %h/%b want aabb33dd/1", nr_doa, nr_va);
    end
    vectors++;
    if (or_va !== 1'b0) begin miscompares++; $display("FAIL bw_or_early: got valid %b want 0", or_va); end
    idle();
    cyc();
    vectors++;
    if (nr_doa !== 32'hAABB33DD || nr_va !== 1'b0) begin
      miscompares++; $display("FAIL bw_hold_nr: got %h/%b want aabb33dd/0", nr_doa, nr_va);
    end
    vectors++;
    if (or_doa !== 32'hAABB33DD || or_va !== 1'b1) begin
      miscompares++; $display("FAIL bw_read_or: got %h/%b want aabb33dd/1", or_doa, or_va);
    end
    cyc();
    vectors++;
    if (or_doa !== 32'hAABB33DD || or_va !== 1'b0) begin
      miscompares++; $display("FAIL bw_hold_or: got %h/%b want aabb33dd/0", or_doa, or_va);
    end
  endtask

  task automatic test_outreg_b2b();
    logic [31:0] exp_d;
    logic        exp_v;
    idle();
    for (int k = 0; k < 4; k++) begin
      ceb = 1; web = 4'hF; addrb = 12'(k); dib = 32'(k);
      cyc();
    end
    web = 4'h0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin ceb = 1; addrb = 12'(k); end else ceb = 0;
      cyc();
      exp_v = (k >= 1 && k <= 4);
      exp_d = (k == 0) ? 32'd0 : (k == 5) ? 32'd3 : 32'(k - 1);
      vectors++;
      if (or_vb !== exp_v || or_dob !== exp_d) begin
        miscompares++;
        $display("FAIL b2b_or[%0d]: got %h/%b want %h/%b", k, or_dob, or_vb, exp_d, exp_v);
      end
      if (k < 4) begin
        vectors++;
        if (nr_vb !== 1'b1 || nr_dob !== 32'(k)) begin
          miscompares++;
          $display("FAIL b2b_nr[%0d]: got %h/%b want %h/1", k, nr_dob, nr_vb, k);
        end
      end
    end
  endtask

  task automatic test_writemode_a();
    idle(); cea = 1; addra = 12'd7; dia = 32'h1; wea = 4'hF;
    cyc();
    vectors++;
    if (wt_doa !== 32'h1 || wt_va !== 1'b1) begin
      miscompares++; $display("FAIL wm_wt_first: got %h/%b want 1/1", wt_doa, wt_va);
    end
    dia = 32'h2;
    cyc();
    vectors++;
    if (nr_doa !== 32'hAABB33DD || nr_va !== 1'b0) begin
      miscompares++; $display("FAIL wm_normal: got %h/%b want aabb33dd/0", nr_doa, nr_va);
    end
    vectors++;
    if (wt_doa !== 32'h2 || wt_va !== 1'b1) begin
      miscompares++; $display("FAIL wm_writethrough: got %h/%b want 2/1", wt_doa, wt_va);
    end
    vectors++;
    if (rb_doa !== 32'h1 || rb_va !== 1'b1) begin
      miscompares++; $display("FAIL wm_readbefore: got %h/%b want 1/1", rb_doa, rb_va);
    end
    idle();
    cyc();
    vectors++;
    if (wt_doa !== 32'h2 || wt_va !== 1'b0) begin
      miscompares++; $display("FAIL wm_wt_hold: got %h/%b want 2/0", wt_doa, wt_va);
    end
  endtask

  task automatic test_dual_write();
    idle(); cea = 1; addra = 12'd9; dia = 32'h0; wea = 4'hF;
    cyc();
    vectors++;
    if (nr_col !== 1'b0) begin miscompares++; $display("FAIL dw_single_col: got %b want 0", nr_col); end
    dia = 32'h11111111; wea = 4'b0011;
    ceb = 1; addrb = 12'd9; dib = 32'h22222222; web = 4'b0110;
    cyc();
    vectors++;
    if (nr_col !== 1'b1) begin miscompares++; $display("FAIL dw_col: got %b want 1", nr_col); end
    idle();
    cyc();
    vectors++;
    if (nr_col !== 1'b0) begin miscompares++; $display("FAIL dw_col_clear: got %b want 0", nr_col); end
    cea = 1; addra = 12'd9;
    cyc();
    vectors++;
    if (nr_doa !== 32'h00221111 || nr_va !== 1'b1) begin
      miscompares++; $display("FAIL dw_merged: got %h/%b want 00221111/1", nr_doa, nr_va);
    end
    idle();
    cyc();
  endtask

  task automatic test_cross_port();
    idle(); cea = 1; addra = 12'd3; dia = 32'h5; wea = 4'hF;
    cyc();
    dia = 32'h6; ceb = 1; addrb = 12'd3;
    cyc();
    vectors++;
    if (nr_dob !== 32'h5 || nr_vb !== 1'b1) begin
      miscompares++; $display("FAIL cp_old_word: got %h/%b want 5/1", nr_dob, nr_vb);
    end
    vectors++;
    if (nr_col !== 1'b1) begin miscompares++; $display("FAIL cp_col: got %b want 1", nr_col); end
    vectors++;
    if (rb_doa !== 32'h5) begin miscompares++; $display("FAIL cp_rb_doa: got %h want 5", rb_doa); end
    idle(); ceb = 1; addrb = 12'd3;
    cyc();
    vectors++;
    if (nr_dob !== 32'h6 || nr_vb !== 1'b1 || nr_col !== 1'b0) begin
      miscompares++; $display("FAIL cp_new_word: got %h/%b col %b want 6/1 col 0", nr_dob, nr_vb, nr_col);
    end
    idle();
    cyc(); cyc();
  endtask

  task automatic test_port_reset();
    idle(); ceb = 1; addrb = 12'd3;
    cyc();
    vectors++;
    if (or_vb !== 1'b0) begin miscompares++; $display("FAIL pr_or_early: got %b want 0", or_vb); end
    idle(); rstb = 1;
    cyc();
    vectors++;
    if (or_dob !== 32'h0 || or_vb !== 1'b0) begin
      miscompares++; $display("FAIL pr_rstb: got %h/%b want 0/0", or_dob, or_vb);
    end
    vectors++;
    if (or_doa !== 32'h00221111) begin
      miscompares++; $display("FAIL pr_other_port: got %h want 00221111", or_doa);
    end
    rstb = 0;
    cyc();
    vectors++;
    if (or_vb !== 1'b0) begin miscompares++; $display("FAIL pr_flushed: got %b want 0", or_vb); end
    ceb = 1; addrb = 12'd3; rstb = 1;
    cea = 1; addra = 12'd12; dia = 32'hCAFEF00D; wea = 4'hF; rsta = 1;
    cyc();
    vectors++;
    if (nr_dob !== 32'h0 || nr_vb !== 1'b0 || nr_doa !== 32'h0 || nr_va !== 1'b0) begin
      miscompares++;
      $display("FAIL pr_priority: got b %h/%b a %h/%b want 0/0 0/0", nr_dob, nr_vb, nr_doa, nr_va);
    end
    idle(); ceb = 1; addrb = 12'd12;
    cyc();
    vectors++;
    if (nr_dob !== 32'hCAFEF00D || nr_vb !== 1'b1) begin
      miscompares++; $display("FAIL pr_write_under_rst: got %h/%b want cafef00d/1", nr_dob, nr_vb);
    end
    idle();
    cyc(); cyc();
  endtask

  task automatic test_async_reset();
    idle(); cea = 1; addra = 12'd3; dia = 32'h6; wea = 4'hF;
    ceb = 1; addrb = 12'd3;
    cyc();
    vectors++;
    if (nr_col !== 1'b1 || nr_dob !== 32'h6) begin
      miscompares++; $display("FAIL ar_pre: got col %b dob %h want 1/6", nr_col, nr_dob);
    end
    idle();
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({nr_doa, nr_dob, nr_va, nr_vb, nr_col} !== 67'd0) begin
      miscompares++;
      $display("FAIL ar_nr_async: got %h %h %b %b %b want all 0", nr_doa, nr_dob, nr_va, nr_vb, nr_col);
    end
    vectors++;
    if ({or_doa, or_dob, or_va, or_vb, or_col} !== 67'd0) begin
      miscompares++;
      $display("FAIL ar_or_async: got %h %h %b %b %b want all 0", or_doa, or_dob, or_va, or_vb, or_col);
    end
    cea = 1; addra = 12'd3; dia = 32'hDEAD; wea = 4'hF;
    cyc();
    rst_n = 1; idle();
    cyc();
    vectors++;
    if (or_vb !== 1'b0 || nr_vb !== 1'b0 || or_dob !== 32'h0) begin
      miscompares++; $display("FAIL ar_discard: got or %h/%b nr %b want 0/0 0", or_dob, or_vb, nr_vb);
    end
    ceb = 1; addrb = 12'd3;
    cyc();
    vectors++;
    if (nr_dob !== 32'h6 || nr_vb !== 1'b1) begin
      miscompares++; $display("FAIL ar_retain: got %h/%b want 6/1", nr_dob, nr_vb);
    end
    idle();
    cyc();
  endtask

  initial begin
    clk = 0; rst_n = 0;
    addra = '0; addrb = '0; dia = '0; dib = '0;
    idle();
    test_reset();
    test_byte_write();
    test_outreg_b2b();
    test_writemode_a();
    test_dual_write();
    test_cross_port();
    test_port_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
